hs_npu_matrix_streamer: RTL and testbench

Parametrised memory-to-array row streamer and the next generation of the NPU layer loader's read path. Fetches a row-major matrix from memory in bursts and unpacks each row's elements at a configurable width. Sign-extends the elements and masks unused columns, optionally right-aligning them, then presents one full array row per handshake to the input or weight FIFOs. Adds what the previous loader lacked: arbitrary element width, multi-beat rows, row stride, FIFO backpressure, abort, and configuration error detection.

---
 rtl/hs_npu_matrix_streamer.sv | 141 ++++++++++++++
 tb/tb_hs_npu_matrix_streamer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hs_npu_matrix_streamer.sv
// Memory-to-array row streamer: fetches row-major matrix rows in bursts, unpacks,
// sign-extends and column-masks the elements, and hands out one array row per handshake.
module hs_npu_matrix_streamer #(
  parameter int SIZE       = 8,
  parameter int ELEM_WIDTH = 8,
  parameter int OUT_WIDTH  = 16,
  parameter int BURST_SIZE = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  output logic                      start_ready_o,
  input  logic [31:0]               base_addr_i,
  input  logic [31:0]               row_stride_i,
  input  logic [31:0]               num_rows_i,
  input  logic [31:0]               num_cols_i,
  input  logic                      right_align_i,
  input  logic                      abort_i,
  output logic                      mem_req_valid_o,
  input  logic                      mem_req_ready_i,
  output logic [31:0]               mem_req_addr_o,
  input  logic                      mem_rsp_valid_i,
  output logic                      mem_rsp_ready_o,
  input  logic [32*BURST_SIZE-1:0]  mem_rsp_data_i,
  output logic                      row_valid_o,
  input  logic                      row_ready_i,
  output logic [OUT_WIDTH*SIZE-1:0] row_data_o,
  output logic                      done_o,
  output logic                      error_o
);
  localparam int BEAT_BITS  = 32 * BURST_SIZE;
  localparam int BEAT_BYTES = 4 * BURST_SIZE;
  localparam int EPB        = BEAT_BITS / ELEM_WIDTH;
  localparam int BEATS      = (SIZE * ELEM_WIDTH + BEAT_BITS - 1) / BEAT_BITS;
  localparam int BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [2:0] {IDLE, REQ, RSP, EMIT, DONE, DRAIN} state_t;

  state_t               state_q, state_d;
  logic [31:0]          row_addr_q, stride_q, row_cnt_q, rows_q, cols_q;
  logic                 align_q, err_q;
  logic [BEAT_W-1:0]    beat_q;
  logic [OUT_WIDTH-1:0] row_q [SIZE];
  logic [OUT_WIDTH-1:0] row_d [SIZE];
  logic [31:0]          elem_base;
  logic                 cfg_ok, last_beat, last_row;

  assign cfg_ok    = (num_rows_i != 32'd0) && (num_cols_i != 32'd0) &&
                     (num_cols_i <= 32'(SIZE));
  assign last_beat = (beat_q == BEAT_W'(BEATS - 1));
  assign last_row  = (row_cnt_q == rows_q - 32'd1);
  assign elem_base = 32'(beat_q) * 32'(EPB);

  // Row address advances by the stride per row, so no multiplier is needed.
  assign mem_req_addr_o  = row_addr_q + 32'(beat_q) * 32'(BEAT_BYTES);
  assign start_ready_o   = (state_q == IDLE);
  assign mem_req_valid_o = (state_q == REQ);
  assign mem_rsp_ready_o = (state_q == RSP) || (state_q == DRAIN);
  assign row_valid_o     = (state_q == EMIT);
  assign done_o          = (state_q == DONE);
  assign error_o         = err_q;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start_i && cfg_ok) state_d = REQ;
      REQ:   if (abort_i) state_d = IDLE;
             else if (mem_req_ready_i) state_d = RSP;
      // A beat arriving with the abort is the one being discarded, so skip DRAIN.
      RSP:   if (abort_i) state_d = mem_rsp_valid_i ? IDLE : DRAIN;
             else if (mem_rsp_valid_i) state_d = last_beat ? EMIT : REQ;
      EMIT:  if (abort_i) state_d = IDLE;
             else if (row_ready_i) state_d = last_row ? DONE : REQ;
      DONE:  state_d = IDLE;
      DRAIN: if (mem_rsp_valid_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Element e lands at index e (or SIZE-cols+e when right-aligned); columns >= cols stay cleared.
  always_comb begin
    row_d = row_q;
    for (int i = 0; i < SIZE; i++) begin
      for (int j = 0; j < EPB; j++) begin
        if ((elem_base + 32'(j) < cols_q) &&
            (align_q ? (elem_base + 32'(j + SIZE) == 32'(i) + cols_q)
                     : (elem_base + 32'(j) == 32'(i))))
          row_d[i] = OUT_WIDTH'($signed(mem_rsp_data_i[j*ELEM_WIDTH +: ELEM_WIDTH]));
      end
    end
  end

  always_comb begin
    row_data_o = '0;
    for (int i = 0; i < SIZE; i++) row_data_o[i*OUT_WIDTH +: OUT_WIDTH] = row_q[i];
  end

  // NOTE: the row buffer is reset as well: row_data_o must read 0 out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      row_addr_q <= '0;
      stride_q   <= '0;
      row_cnt_q  <= '0;
      rows_q     <= '0;
      cols_q     <= '0;
      align_q    <= 1'b0;
      err_q      <= 1'b0;
      beat_q     <= '0;
      for (int i = 0; i < SIZE; i++) row_q[i] <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= 1'b0;
      case (state_q)
        IDLE: if (start_i) begin
          row_addr_q <= base_addr_i;
          stride_q   <= row_stride_i;
          rows_q     <= num_rows_i;
          cols_q     <= num_cols_i;
          align_q    <= right_align_i;
          err_q      <= !cfg_ok;
          row_cnt_q  <= '0;
          beat_q     <= '0;
          for (int i = 0; i < SIZE; i++) row_q[i] <= '0;
        end
        RSP: if (mem_rsp_valid_i && !abort_i) begin
          row_q <= row_d;
          if (!last_beat) beat_q <= beat_q + BEAT_W'(1);
        end
        EMIT: if (row_ready_i && !abort_i && !last_row) begin
          row_cnt_q  <= row_cnt_q + 32'd1;
          beat_q     <= '0;
          row_addr_q <= row_addr_q + stride_q;
          for (int i = 0; i < SIZE; i++) row_q[i] <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_hs_npu_matrix_streamer.sv
// Self-checking bench: two streamer instances (8-bit and 16-bit elements) driven by
// directed and randomized commands against a byte-addressed memory/row reference model.
module tb_hs_npu_matrix_streamer;
  localparam int SIZE = 8;
  localparam int OW   = 16;
  localparam int RW   = SIZE * OW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, ra, abort, req_ready, rsp_valid, row_ready;
  logic [31:0] base, stride, rows, cols;
  logic [63:0] rsp_data;
  int          sel;
  int          n_tests, n_fail;
  logic [31:0] salt;

  logic          a_start_ready, a_req_valid, a_rsp_ready, a_row_valid, a_done, a_error;
  logic          b_start_ready, b_req_valid, b_rsp_ready, b_row_valid, b_done, b_error;
  logic [31:0]   a_req_addr, b_req_addr;
  logic [RW-1:0] a_row_data, b_row_data;
  logic          start_a, start_b;

  assign start_a = start && (sel == 0);
  assign start_b = start && (sel == 1);

  logic          o_start_ready, o_req_valid, o_rsp_ready, o_row_valid, o_done, o_error;
  logic [31:0]   o_req_addr;
  logic [RW-1:0] o_row_data;
  assign o_start_ready = (sel == 1) ? b_start_ready : a_start_ready;
  assign o_req_valid   = (sel == 1) ? b_req_valid   : a_req_valid;
  assign o_rsp_ready   = (sel == 1) ? b_rsp_ready   : a_rsp_ready;
  assign o_row_valid   = (sel == 1) ? b_row_valid   : a_row_valid;
  assign o_done        = (sel == 1) ? b_done        : a_done;
  assign o_error       = (sel == 1) ? b_error       : a_error;
  assign o_req_addr    = (sel == 1) ? b_req_addr    : a_req_addr;
  assign o_row_data    = (sel == 1) ? b_row_data    : a_row_data;

  hs_npu_matrix_streamer #(.SIZE(8), .ELEM_WIDTH(8), .OUT_WIDTH(16), .BURST_SIZE(2)) u_dut8 (
    .clk(clk), .rst(rst), .start_i(start_a), .start_ready_o(a_start_ready),
    .base_addr_i(base), .row_stride_i(stride), .num_rows_i(rows), .num_cols_i(cols),
    .right_align_i(ra), .abort_i(abort), .mem_req_valid_o(a_req_valid),
    .mem_req_ready_i(req_ready), .mem_req_addr_o(a_req_addr), .mem_rsp_valid_i(rsp_valid),
    .mem_rsp_ready_o(a_rsp_ready), .mem_rsp_data_i(rsp_data), .row_valid_o(a_row_valid),
    .row_ready_i(row_ready), .row_data_o(a_row_data), .done_o(a_done), .error_o(a_error));

  hs_npu_matrix_streamer #(.SIZE(8), .ELEM_WIDTH(16), .OUT_WIDTH(16), .BURST_SIZE(2)) u_dut16 (
    .clk(clk), .rst(rst), .start_i(start_b), .start_ready_o(b_start_ready),
    .base_addr_i(base), .row_stride_i(stride), .num_rows_i(rows), .num_cols_i(cols),
    .right_align_i(ra), .abort_i(abort), .mem_req_valid_o(b_req_valid),
    .mem_req_ready_i(req_ready), .mem_req_addr_o(b_req_addr), .mem_rsp_valid_i(rsp_valid),
    .mem_rsp_ready_o(b_rsp_ready), .mem_rsp_data_i(rsp_data), .row_valid_o(b_row_valid),
    .row_ready_i(row_ready), .row_data_o(b_row_data), .done_o(b_done), .error_o(b_error));

  task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Byte-addressed memory: explicit bytes where written, salted hash elsewhere.
  logic [7:0] mem [logic [31:0]];

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [31:0] h;
    if (mem.exists(a)) return mem[a];
    h = (a ^ salt) * 32'h9E37_79B1;
    return h[31:24];
  endfunction

  function automatic logic [63:0] beat_of(input logic [31:0] a);
    logic [63:0] d;
    d = '0;
    for (int k = 0; k < 8; k++) d[8*k +: 8] = mem_byte(a + 32'(k));
    return d;
  endfunction

  // Element e of row r lives at byte base + r*stride + e*bytes, little-endian.
  function automatic logic [RW-1:0] exp_row(input int ew, input logic [31:0] b, st, r,
                                            input int c, input logic ralign);
    logic [RW-1:0] res;
    logic [31:0]   a;
    logic [7:0]    lo, hi;
    int            e;
    res = '0;
    for (int i = 0; i < SIZE; i++) begin
      e = ralign ? i - (SIZE - c) : i;
      if (e >= 0 && e < c) begin
        a  = b + r * st + 32'(e * ew / 8);
        lo = mem_byte(a);
        hi = (ew == 16) ? mem_byte(a + 32'd1) : {8{lo[7]}};
        res[i*OW +: OW] = {hi, lo};
      end
    end
    return res;
  endfunction

  task automatic run_cmd(input int s, input logic [31:0] b, st, input int r, c,
                         input logic ralign, input int req_stall, row_stall, input bit rnd);
    int ew, beats, rows_seen, cycles, req_wait, row_wait, n_req;
    int addr_unstable, row_unstable, overlap, spurious;
    bit pending, done_due, hreq, hrow, finished;
    logic [31:0]   pend_addr, haddr, exp_a;
    logic [RW-1:0] hdata;
    logic [31:0]   exp_addr [$];
    ew = (s == 1) ? 16 : 8;
    beats = (s == 1) ? 2 : 1;
    {rows_seen, cycles, req_wait, row_wait, n_req} = '0;
    {addr_unstable, row_unstable, overlap, spurious} = '0;
    {pending, done_due, hreq, hrow, finished} = '0;
    pend_addr = '0; haddr = '0; hdata = '0;
    for (int rr = 0; rr < r; rr++)
      for (int bt = 0; bt < beats; bt++)
        exp_addr.push_back(b + 32'(rr) * st + 32'(bt * 8));
    sel = s;
    @(negedge clk);
    check("start_ready before cmd", o_start_ready, 1);
    start = 1; base = b; stride = st; rows = 32'(r); cols = 32'(c); ra = ralign;
    @(negedge clk);
    start = 0; base = $urandom; stride = $urandom; rows = $urandom; cols = $urandom; ra = 1'($urandom);
    while (!finished && cycles < 3000) begin
      cycles++;
      if (done_due) begin
        check("done pulse after last row", o_done, 1);
        finished = 1;
      end else if (o_done || o_error) spurious++;
      req_ready = 0; rsp_valid = 0; row_ready = 0;
      rsp_data = {$urandom, $urandom};
      if (!finished) begin
        if (o_req_valid && (o_row_valid || pending)) overlap++;
        if (o_req_valid) begin
          if (hreq && o_req_addr !== haddr) addr_unstable++;
          hreq = 1; haddr = o_req_addr;
          if (req_wait < req_stall) req_wait++;
          else if (!rnd || $urandom_range(0, 2) != 0) begin
            req_ready = 1;
            exp_a = 'x;
            if (exp_addr.size() > 0) exp_a = exp_addr.pop_front();
            check($sformatf("req addr #%0d", n_req), o_req_addr, exp_a);
            n_req++;
            pending = 1; pend_addr = o_req_addr; hreq = 0; req_wait = 0;
          end
        end else if (hreq) addr_unstable++;
        if (pending && o_rsp_ready && (!rnd || $urandom_range(0, 1) == 1)) begin
          rsp_valid = 1; rsp_data = beat_of(pend_addr); pending = 0;
        end
        if (o_row_valid) begin
          if (hrow && o_row_data !== hdata) row_unstable++;
          hrow = 1; hdata = o_row_data;
          if (row_wait < row_stall) row_wait++;
          else if (!rnd || $urandom_range(0, 2) != 0) begin
            row_ready = 1;
            check($sformatf("row %0d data", rows_seen), o_row_data,
                  exp_row(ew, b, st, 32'(rows_seen), c, ralign));
            rows_seen++; hrow = 0; row_wait = 0;
            if (rows_seen == r) done_due = 1;
          end
        end else if (hrow) row_unstable++;
      end
      @(negedge clk);
    end
    check("idle after done", {o_start_ready, o_done}, 2'b10);
    check("command completed", finished, 1);
    check("rows streamed", rows_seen, r);
    check("requests remaining", exp_addr.size(), 0);
    check("req addr stable", addr_unstable, 0);
    check("row data stable", row_unstable, 0);
    check("req/row overlap", overlap, 0);
    check("spurious done/error", spurious, 0);
    if (!rnd && req_stall == 0 && row_stall == 0)
      check("min latency cycles", cycles, r * (2 * beats + 1) + 1);
  endtask

  task automatic abort_test();
    int bad;
    sel = 0; bad = 0;
    @(negedge clk);
    start = 1; base = 32'h300; stride = 32'd8; rows = 32'd2; cols = 32'd8; ra = 0;
    @(negedge clk); start = 0;
    check("req before abort", o_req_valid, 1);
    abort = 1;
    @(negedge clk); abort = 0;
    check("abort in REQ -> idle", {o_start_ready, o_req_valid, o_rsp_ready, o_row_valid, o_done}, 5'b10000);
    start = 1;
    @(negedge clk); start = 0;
    check("req before rsp abort", o_req_valid, 1);
    req_ready = 1;
    @(negedge clk); req_ready = 0;
    check("rsp_ready in RSP", o_rsp_ready, 1);
    abort = 1;
    @(negedge clk); abort = 0;
    check("drain keeps rsp_ready", {o_start_ready, o_rsp_ready, o_req_valid}, 3'b010);
    @(negedge clk);
    check("drain waits for beat", {o_start_ready, o_rsp_ready}, 2'b01);
    rsp_valid = 1; rsp_data = beat_of(32'h300);
    @(negedge clk); rsp_valid = 0;
    check("idle after drain", {o_start_ready, o_rsp_ready, o_row_valid}, 3'b100);
    repeat (5) begin
      if (o_row_valid || o_done || o_req_valid) bad++;
      @(negedge clk);
    end
    check("quiet after abort", bad, 0);
  endtask

  task automatic err_cmd(input logic [31:0] r, c, input string tag);
    int errs, reqs;
    sel = 0; errs = 0; reqs = 0;
    @(negedge clk);
    start = 1; base = 32'h400; stride = 32'd8; rows = r; cols = c; ra = 0;
    @(negedge clk); start = 0;
    check({tag, " error pulse"}, {o_error, o_start_ready, o_req_valid}, 3'b110);
    repeat (5) begin
      @(negedge clk);
      if (o_error || o_done) errs++;
      if (o_req_valid) reqs++;
    end
    check({tag, " single pulse"}, errs, 0);
    check({tag, " no requests"}, reqs, 0);
  endtask

  initial begin
    n_tests = 0; n_fail = 0; salt = $urandom;
    rst = 1; start = 0; ra = 0; abort = 0; req_ready = 0; rsp_valid = 0; row_ready = 0;
    base = '0; stride = '0; rows = '0; cols = '0; rsp_data = '0; sel = 0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s;
      @(negedge clk);
      check($sformatf("reset ctrl dut%0d", s),
            {o_start_ready, o_req_valid, o_rsp_ready, o_row_valid, o_done, o_error}, 6'b100000);
      check($sformatf("reset row dut%0d", s), o_row_data, '0);
    end
    rst = 0;

    for (int r = 0; r < 3; r++)
      for (int k = 0; k < 8; k++) mem[32'h100 + 32'(8 * r + k)] = 8'(8'h81 + k);
    run_cmd(0, 32'h100, 32'd8, 3, 8, 1'b0, 0, 0, 1'b0);

    for (int k = 0; k < 8; k++) mem[32'h200 + 32'(k)] = 8'(k + 1);
    run_cmd(0, 32'h200, 32'd8, 1, 5, 1'b1, 0, 0, 1'b0);
    run_cmd(0, 32'h200, 32'd8, 1, 5, 1'b0, 0, 0, 1'b0);

    mem[32'h1000] = 8'h00; mem[32'h1001] = 8'h80;
    run_cmd(1, 32'h1000, 32'h40, 2, 8, 1'b0, 0, 0, 1'b0);
    run_cmd(1, 32'h1000, 32'h40, 2, 6, 1'b1, 0, 0, 1'b0);

    run_cmd(0, 32'h100, 32'd8, 2, 8, 1'b0, 0, 10, 1'b0);

    abort_test();
    run_cmd(0, 32'h300, 32'd8, 2, 8, 1'b0, 0, 0, 1'b1);

    err_cmd(32'd2, 32'd9, "cols9");
    err_cmd(32'd0, 32'd4, "rows0");
    err_cmd(32'd2, 32'd0, "cols0");
    run_cmd(1, 32'h2000, 32'h20, 2, 7, 1'b1, 5, 0, 1'b0);

    run_cmd(0, 32'hFFFF_FFF8, 32'd8, 2, 8, 1'b0, 0, 0, 1'b0);

    sel = 0;
    @(negedge clk);
    start = 1; base = 32'h500; stride = 32'd8; rows = 32'd2; cols = 32'd8; ra = 0;
    @(negedge clk); start = 0; req_ready = 1;
    @(negedge clk); req_ready = 0;
    check("rsp_ready before reset", o_rsp_ready, 1);
    rst = 1;
    @(negedge clk); rst = 0;
    check("mid-transfer reset ctrl",
          {o_start_ready, o_req_valid, o_rsp_ready, o_row_valid, o_done, o_error}, 6'b100000);
    check("mid-transfer reset addr", o_req_addr, '0);

    for (int t = 0; t < 24; t++)
      run_cmd($urandom_range(0, 1), $urandom, ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 255)),
              $urandom_range(1, 4), $urandom_range(1, 8), 1'($urandom), 0, 0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
